// File: rtl/calc_pkg.sv
// Shared constants, FSM state type and small helpers for the calculator
// operand-entry / operation-sequencing controller.
package calc_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_MOD  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_NAND = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd9;
    localparam logic [3:0] OP_XNOR = 4'd10;
    localparam logic [3:0] OP_CMP  = 4'd11;
    localparam logic [3:0] OP_SHL  = 4'd12;
    localparam logic [3:0] OP_SHR  = 4'd13;
    localparam logic [3:0] OP_ROL  = 4'd14;
    localparam logic [3:0] OP_CS   = 4'd15;

    // Codes matching this mask operate on the previous result (chained ops).
    localparam logic [3:0] OP_SHIFT_MASK = 4'b1100;

    localparam logic [1:0] SEL_A_LO = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_A_HI = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    function automatic int hist_idx_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic logic [3:0] nib_step(input logic [3:0] nib, input logic down);
        return down ? (nib - 4'd1) : (nib + 4'd1);
    endfunction

    function automatic logic is_shift_op(input logic [3:0] code);
        return (code & OP_SHIFT_MASK) == OP_SHIFT_MASK;
    endfunction

endpackage

// File: rtl/calc_seq_ctrl_if.sv
// Start/done handshake between the sequencing controller and the
// arithmetic/logic datapath.
interface calc_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic                 op_start;
    logic [3:0]           op_code;
    logic [2*WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 op_done;
    logic [2*WIDTH-1:0]   op_result;
    logic                 op_err;

    modport master (
        output op_start, op_code, op_a, op_b,
        input  op_done, op_result, op_err
    );

    modport slave (
        input  op_start, op_code, op_a, op_b,
        output op_done, op_result, op_err
    );
endinterface

// File: rtl/btn_rise.sv
// Registers a vector of debounced button levels once and flags the
// cycle in which each bit first reads high.
module btn_rise #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] lvl,
    output logic [W-1:0] rise
);

    logic [W-1:0] cur_r;
    logic [W-1:0] prev_r;

    // Level sample plus one cycle of history for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_r  <= {W{1'b0}};
            prev_r <= {W{1'b0}};
        end else begin
            cur_r  <= lvl;
            prev_r <= cur_r;
        end
    end

    assign rise = cur_r & ~prev_r;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Operand editing, single-operation launch/timeout sequencing, result
// accumulator and history ring buffer for the board calculator.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int HIST_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [WIDTH/4-1:0]                     digit_btn,
    input  logic                                   dec,
    input  logic [1:0]                             sel,
    input  logic [3:0]                             op,
    input  logic                                   exec_btn,
    input  logic                                   hist_btn,
    output logic [2*WIDTH-1:0]                     num_a,
    output logic [WIDTH-1:0]                       num_b,
    calc_seq_ctrl_if.master                        dp,
    output logic                                   busy,
    output logic [2*WIDTH-1:0]                     result,
    output logic                                   err,
    output logic [2*WIDTH-1:0]                     hist_out,
    output logic [hist_idx_width(HIST_DEPTH)-1:0]  hist_idx
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = hist_idx_width(HIST_DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [NIB-1:0]       digit_rise_s;
    logic                 exec_rise_s;
    logic                 hist_rise_s;

    logic [2*WIDTH-1:0]   num_a_r, num_a_nxt_s;
    logic [WIDTH-1:0]     num_b_r, num_b_nxt_s;

    state_e               state_r, state_nxt_s;
    logic                 launch_s, done_s, timeout_s;
    logic [CNT_W-1:0]     cnt_r;
    logic                 start_r, busy_r;
    logic [3:0]           code_r;
    logic [2*WIDTH-1:0]   opa_r;
    logic [WIDTH-1:0]     opb_r;
    logic [2*WIDTH-1:0]   result_r;
    logic                 err_r;

    logic [2*WIDTH-1:0]   hist_mem_r [HIST_DEPTH];
    logic [IDX_W-1:0]     wr_ptr_r, hist_idx_r, rd_ptr_s;

    btn_rise #(.W(NIB)) u_digit_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .lvl   (digit_btn),
        .rise  (digit_rise_s)
    );

    btn_rise #(.W(1)) u_exec_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .lvl   (exec_btn),
        .rise  (exec_rise_s)
    );

    btn_rise #(.W(1)) u_hist_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .lvl   (hist_btn),
        .rise  (hist_rise_s)
    );

    // Per-nibble +/-1 edits; nibbles wrap independently, no carry
    always_comb begin
        num_a_nxt_s = num_a_r;
        num_b_nxt_s = num_b_r;
        for (int i = 0; i < NIB; i++) begin
            case (sel)
                SEL_A_LO: num_a_nxt_s[4*i +: 4] = digit_rise_s[i] ?
                              nib_step(num_a_r[4*i +: 4], dec) : num_a_r[4*i +: 4];
                SEL_A_HI: num_a_nxt_s[WIDTH+4*i +: 4] = digit_rise_s[i] ?
                              nib_step(num_a_r[WIDTH+4*i +: 4], dec) : num_a_r[WIDTH+4*i +: 4];
                SEL_B:    num_b_nxt_s[4*i +: 4] = digit_rise_s[i] ?
                              nib_step(num_b_r[4*i +: 4], dec) : num_b_r[4*i +: 4];
                default:  num_b_nxt_s[4*i +: 4] = num_b_r[4*i +: 4];
            endcase
        end
    end

    // Operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_a_r <= {(2*WIDTH){1'b0}};
            num_b_r <= {WIDTH{1'b0}};
        end else begin
            num_a_r <= num_a_nxt_s;
            num_b_r <= num_b_nxt_s;
        end
    end

    // Sequencer next-state; done takes priority over an expiring timeout
    always_comb begin
        state_nxt_s = state_r;
        launch_s    = 1'b0;
        done_s      = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (exec_rise_s) begin
                    state_nxt_s = ISSUE;
                    launch_s    = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: state_nxt_s = WAIT;
            WAIT: begin
                if (dp.op_done) begin
                    state_nxt_s = IDLE;
                    done_s      = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = IDLE;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Sequencer state, wait counter, launch pulse and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            start_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= (state_r == WAIT) ? (cnt_r + CNT_W'(1'b1)) : {CNT_W{1'b0}};
            start_r <= launch_s;
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    // Launch snapshot, accumulator and error status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_r   <= 4'd0;
            opa_r    <= {(2*WIDTH){1'b0}};
            opb_r    <= {WIDTH{1'b0}};
            result_r <= {(2*WIDTH){1'b0}};
            err_r    <= 1'b0;
        end else if (launch_s) begin
            code_r <= op;
            opa_r  <= is_shift_op(op) ? result_r : num_a_r;
            opb_r  <= num_b_r;
            err_r  <= 1'b0;
        end else if (done_s) begin
            result_r <= dp.op_result;
            err_r    <= dp.op_err;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end
    end

    // History ring buffer; a push resets the view to the newest entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_mem_r[i] <= {(2*WIDTH){1'b0}};
            end
            wr_ptr_r   <= {IDX_W{1'b0}};
            hist_idx_r <= {IDX_W{1'b0}};
        end else if (done_s) begin
            hist_mem_r[wr_ptr_r] <= dp.op_result;
            wr_ptr_r             <= wr_ptr_r + IDX_W'(1'b1);
            hist_idx_r           <= {IDX_W{1'b0}};
        end else if (hist_rise_s) begin
            hist_idx_r <= hist_idx_r + IDX_W'(1'b1);
        end
    end

    assign rd_ptr_s = wr_ptr_r - IDX_W'(1'b1) - hist_idx_r;

    assign num_a       = num_a_r;
    assign num_b       = num_b_r;
    assign dp.op_start = start_r;
    assign dp.op_code  = code_r;
    assign dp.op_a     = opa_r;
    assign dp.op_b     = opb_r;
    assign busy        = busy_r;
    assign result      = result_r;
    assign err         = err_r;
    assign hist_out    = hist_mem_r[rd_ptr_s];
    assign hist_idx    = hist_idx_r;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed plus randomized bench for calc_seq_ctrl with a nibble-array /
// queue reference model and a scripted datapath responder.
module tb_calc_seq_ctrl;

    localparam int WIDTH = 32;
    localparam int HD    = 4;
    localparam int TO    = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  digit_btn;
    logic        dec;
    logic [1:0]  sel;
    logic [3:0]  op;
    logic        exec_btn;
    logic        hist_btn;
    logic [63:0] num_a;
    logic [31:0] num_b;
    logic        busy;
    logic [63:0] result;
    logic        err;
    logic [63:0] hist_out;
    logic [1:0]  hist_idx;

    calc_seq_ctrl_if #(.WIDTH(WIDTH)) dp_if ();

    calc_seq_ctrl #(.WIDTH(WIDTH), .HIST_DEPTH(HD), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digit_btn (digit_btn),
        .dec       (dec),
        .sel       (sel),
        .op        (op),
        .exec_btn  (exec_btn),
        .hist_btn  (hist_btn),
        .num_a     (num_a),
        .num_b     (num_b),
        .dp        (dp_if),
        .busy      (busy),
        .result    (result),
        .err       (err),
        .hist_out  (hist_out),
        .hist_idx  (hist_idx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          a_nib [16];
    int          b_nib [8];
    logic [63:0] m_res;
    logic        m_err;
    logic [63:0] m_hist [$];
    int          m_idx;
    logic [3:0]  m_code;
    logic [63:0] m_opa;
    logic [31:0] m_opb;

    function automatic logic [63:0] a_val();
        logic [63:0] v = 64'd0;
        for (int i = 15; i >= 0; i--) v = v * 64'd16 + 64'(a_nib[i]);
        return v;
    endfunction

    function automatic logic [31:0] b_val();
        logic [31:0] v = 32'd0;
        for (int i = 7; i >= 0; i--) v = v * 32'd16 + 32'(b_nib[i]);
        return v;
    endfunction

    function automatic int nstep(input int v, input logic d);
        return d ? (v + 15) % 16 : (v + 1) % 16;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) a_nib[i] = 0;
        for (int i = 0; i < 8; i++) b_nib[i] = 0;
        m_res  = 64'd0;
        m_err  = 1'b0;
        m_hist = {};
        for (int i = 0; i < HD; i++) m_hist.push_back(64'd0);
        m_idx  = 0;
        m_code = 4'd0;
        m_opa  = 64'd0;
        m_opb  = 32'd0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".num_a"},    num_a, a_val());
        check({tag, ".num_b"},    64'(num_b), 64'(b_val()));
        check({tag, ".result"},   result, m_res);
        check({tag, ".err"},      64'(err), 64'(m_err));
        check({tag, ".hist_out"}, hist_out, m_hist[m_idx]);
        check({tag, ".hist_idx"}, 64'(hist_idx), 64'(m_idx));
        check({tag, ".op_code"},  64'(dp_if.op_code), 64'(m_code));
        check({tag, ".op_a"},     dp_if.op_a, m_opa);
        check({tag, ".op_b"},     64'(dp_if.op_b), 64'(m_opb));
    endtask

    task automatic press(input logic [7:0] mask, input logic d, input logic [1:0] s);
        digit_btn = mask; dec = d; sel = s;
        tick();
        digit_btn = 8'd0;
        tick();
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                case (s)
                    2'b00:   a_nib[i]     = nstep(a_nib[i], d);
                    2'b10:   a_nib[i + 8] = nstep(a_nib[i + 8], d);
                    2'b01:   b_nib[i]     = nstep(b_nib[i], d);
                    default: ;
                endcase
            end
        end
        check("press.num_a", num_a, a_val());
        check("press.num_b", 64'(num_b), 64'(b_val()));
    endtask

    task automatic hist_press();
        hist_btn = 1'b1;
        tick();
        hist_btn = 1'b0;
        tick();
        m_idx = (m_idx + 1) % HD;
        check("hist.idx", 64'(hist_idx), 64'(m_idx));
        check("hist.out", hist_out, m_hist[m_idx]);
    endtask

    // lat < 0: datapath never answers; lat >= 1: done driven lat cycles after op_start
    task automatic run_op(input logic [3:0] code, input int lat, input logic [63:0] res,
                          input logic e, input bit coinc, input bit poke);
        int cnt;
        m_code = code;
        m_opa  = (code >= 4'd12) ? m_res : a_val();
        m_opb  = b_val();
        op = code;
        exec_btn = 1'b1;
        tick();
        exec_btn = 1'b0;
        check("launch.early_start", 64'(dp_if.op_start), 64'd0);
        check("launch.early_busy", 64'(busy), 64'd0);
        tick();
        check("launch.start", 64'(dp_if.op_start), 64'd1);
        check("launch.busy", 64'(busy), 64'd1);
        check("launch.op_code", 64'(dp_if.op_code), 64'(m_code));
        check("launch.op_a", dp_if.op_a, m_opa);
        check("launch.op_b", 64'(dp_if.op_b), 64'(m_opb));
        if (lat < 0) begin
            cnt = 0;
            do begin
                tick();
                cnt++;
                if (cnt == 1) check("to.start_pulse", 64'(dp_if.op_start), 64'd0);
            end while (busy === 1'b1 && cnt < 4 * TO);
            check("to.len", 64'(cnt), 64'(TO + 1));
            m_err = 1'b1;
        end else begin
            for (int k = 0; k < lat; k++) begin
                if (coinc && k == lat - 1) hist_btn = 1'b1;
                if (poke && k == 1) begin exec_btn = 1'b1; op = ~code; end
                if (poke && k == 2) exec_btn = 1'b0;
                tick();
                if (k == 0) check("op.start_pulse", 64'(dp_if.op_start), 64'd0);
                if (poke && k > 0) check("poke.no_start", 64'(dp_if.op_start), 64'd0);
            end
            check("op.busy_wait", 64'(busy), 64'd1);
            dp_if.op_done = 1'b1; dp_if.op_result = res; dp_if.op_err = e;
            tick();
            dp_if.op_done = 1'b0; dp_if.op_result = {$urandom, $urandom}; dp_if.op_err = 1'b0;
            hist_btn = 1'b0;
            exec_btn = 1'b0;
            m_res = res;
            m_err = e;
            m_hist.push_front(res);
            void'(m_hist.pop_back());
            m_idx = 0;
        end
        check("op.busy_end", 64'(busy), 64'd0);
        check_all("op.end");
        if (poke) begin
            for (int k = 0; k < 3; k++) begin
                tick();
                check("poke.dropped_start", 64'(dp_if.op_start), 64'd0);
                check("poke.dropped_busy", 64'(busy), 64'd0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; digit_btn = 8'd0; dec = 1'b0; sel = 2'b00; op = 4'd0;
        exec_btn = 1'b0; hist_btn = 1'b0;
        dp_if.op_done = 1'b0; dp_if.op_result = 64'd0; dp_if.op_err = 1'b0;
        model_reset();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst.start", 64'(dp_if.op_start), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check_all("rst");

        // digit editing with wrap
        repeat (3) press(8'h01, 1'b0, 2'b00);
        check("edit.a_is_3", num_a, 64'h3);
        repeat (4) press(8'h01, 1'b1, 2'b00);
        check("edit.a_low_byte", 64'(num_a[7:0]), 64'h0F);
        repeat (6) press(8'h01, 1'b0, 2'b00);
        repeat (7) press(8'h01, 1'b0, 2'b01);
        press(8'hFF, 1'b0, 2'b11);
        check("edit.a_is_5", num_a, 64'h5);
        check("edit.b_is_7", 64'(num_b), 64'h7);

        // basic ADD
        run_op(4'd0, 2, 64'd12, 1'b0, 1'b0, 1'b0);
        check("add.result", result, 64'd12);
        check("add.hist", hist_out, 64'd12);

        // chained shift-group op takes the previous result
        run_op(4'd0, 1, 64'h8000_0001, 1'b0, 1'b0, 1'b0);
        press(8'h03, 1'b0, 2'b10);
        run_op(4'b1111, 1, 64'h0000_0003, 1'b0, 1'b0, 1'b0);
        check("chain.op_a", dp_if.op_a, 64'h8000_0001);

        // timeout
        run_op(4'd3, -1, 64'd0, 1'b0, 1'b0, 1'b0);
        check("to.result_kept", result, 64'h3);
        check("to.err", 64'(err), 64'd1);

        // history depth and wrap
        for (int r = 1; r <= 5; r++) run_op(4'd1, 1, 64'(r), 1'b0, 1'b0, 1'b0);
        check("hist.newest", hist_out, 64'd5);
        repeat (4) hist_press();
        hist_press();
        run_op(4'd2, 1, 64'hABCD, 1'b1, 1'b1, 1'b0);
        check("hist.coinc_idx", 64'(hist_idx), 64'd0);

        // exec during WAIT dropped; done outside WAIT ignored
        run_op(4'd6, 4, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 1'b1);
        dp_if.op_done = 1'b1; dp_if.op_result = 64'hDEAD; dp_if.op_err = 1'b1;
        tick(); tick();
        dp_if.op_done = 1'b0; dp_if.op_err = 1'b0;
        tick();
        check_all("idle_done");

        // randomized editing, history browsing and operations
        for (int n = 0; n < 14; n++) begin
            repeat (3) press(8'($urandom), 1'($urandom), 2'($urandom));
            if ($urandom_range(0, 2) == 0) hist_press();
            run_op(4'($urandom), int'($urandom_range(1, 5)), {$urandom, $urandom},
                   1'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0);
        end

        // asynchronous reset during WAIT
        op = 4'd4;
        exec_btn = 1'b1;
        tick();
        exec_btn = 1'b0;
        tick(); tick(); tick();
        check("arst.pre_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst.start", 64'(dp_if.op_start), 64'd0);
        check("arst.busy", 64'(busy), 64'd0);
        check_all("arst");
        tick();
        rst_n = 1'b1;
        tick();
        check_all("arst.release");
        press(8'h01, 1'b0, 2'b00);
        run_op(4'd0, 3, 64'h77, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_seq_ctrl.md
# calc_seq_ctrl

Parametrised operand-entry and operation-sequencing controller for the board calculator. It sits between the debounced push-button inputs and the arithmetic/logic datapath (adders, multipliers, dividers, shifters). It edits operands nibble-by-nibble on the system clock and launches one operation at a time through a start/done handshake with timeout. It keeps a registered accumulator and a browsable history of past results for the display blocks.

## Interface
Parameters:
- `WIDTH`, 32, operand B width; operand A and results are 2*WIDTH wide; must be a multiple of 4.
- `HIST_DEPTH`, 4, number of history entries; power of 2, ≥2.
- `TIMEOUT`, 64, maximum cycles to wait for `op_done` before aborting; ≥2.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `digit_btn` in WIDTH/4: debounced levels; a rising edge on bit i steps nibble i of the selected field.
- `dec` in 1: step direction; 1 = −1, 0 = +1.
- `sel` in 2: edit target; 00 = A[WIDTH-1:0], 10 = A[2W-1:W], 01 = B, 11 = none.
- `op` in 4: operation code, sampled on an exec edge.
- `exec_btn` in 1: debounced level; a rising edge requests execution.
- `hist_btn` in 1: debounced level; a rising edge steps the history view one entry older.
- `num_a` out 2*WIDTH, `num_b` out WIDTH: live operand registers.
- `op_start` out 1: one-cycle launch pulse.
- `op_code` out 4, `op_a` out 2*WIDTH, `op_b` out WIDTH: snapshot of the launched operation, held stable until the next launch.
- `op_done` in 1, `op_result` in 2*WIDTH, `op_err` in 1: datapath completion.
- `busy` out 1, `result` out 2*WIDTH, `err` out 1: accumulator and status.
- `hist_out` out 2*WIDTH, `hist_idx` out log2(HIST_DEPTH): selected history entry and its age (0 = newest).

## Operation
- Button edges: each button input is registered once; rise = current & ~previous. All edges are synchronous to `clk`; no button drives a clock.
- Digit step: the nibble changes by +1 or −1 mod 16 (F+1→0, 0−1→F), with no carry into neighbouring nibbles. Several simultaneous digit edges all step. `sel`=11 ignores edits. Editing is allowed while `busy`.
- FSM states:
  - IDLE: an exec rise → ISSUE. The snapshot captures `op_code`←`op` and `op_b`←`num_b`. `op_a`←`num_a`, except for codes 4'b11xx (shift group), which take `op_a`←`result` (chained operation on the last result). `err`←0.
  - ISSUE: `op_start`=1 for one cycle → WAIT. The timeout counter clears.
  - WAIT: `op_done`=1 → IDLE with `result`←`op_result` and `err`←`op_err`; the result is pushed into history. Counter reaching TIMEOUT−1 without done → IDLE with `err`←1, `result` unchanged, no history push.
- Exec rises while `busy` are dropped, not queued. `op_done` outside WAIT is ignored.
- History: ring buffer with write pointer. A push writes the newest entry and forces `hist_idx`←0. A hist rise sets `hist_idx`←(`hist_idx`+1) mod HIST_DEPTH. A push and a hist rise in the same cycle: the push wins and `hist_idx`=0. `hist_out` = entry (wr_ptr−1−hist_idx) mod HIST_DEPTH, driven combinationally from registers.
- Reset: `num_a`, `num_b`, `result`, snapshots, and all history entries are 0. `err`=0, `busy`=0, `op_start`=0, `hist_idx`=0, FSM in IDLE, edge registers 0.

## Timing
- If exec is first sampled high at edge t, ISSUE is entered at t+1 and `op_start` is high between edges t+1 and t+2.
- `busy` is high from edge t+1 until the edge at which `op_done` is sampled in WAIT.
- With `op_done` tied high (combinational datapath), `result` is valid after edge t+3.
- A digit edge sampled at edge t updates the nibble at edge t+1.
- A timeout fires at the TIMEOUT-th WAIT cycle.
- Asserting reset mid-operation aborts immediately and returns to reset values. The datapath must tolerate an abandoned start.

## Structure
- `calc_pkg`: op-code constants (ADD=0 … CS=15, `OP_SHIFT_MASK`=4'b1100), FSM state enum {IDLE, ISSUE, WAIT}, helper function computing the history index width.
- Sub-module `btn_rise`: parametrised-width register plus rising-edge detect. Instantiated for digit, exec and hist buttons.

## Test plan
- Reset, `sel`=00, `dec`=0, three rises on `digit_btn[0]` → `num_a`=3. With `dec`=1, four rises → `num_a[3:0]`=F and `num_a[7:4]`=0.
- `num_a`=5, `num_b`=7, `op`=0, exec rise, model returns 12 with done two cycles after `op_start` → one-cycle `op_start`, `op_a`=5, `op_b`=7, then `result`=12, `err`=0, `hist_out`=12.
- `result`=0x80000001, `op`=4'b1111, exec rise → `op_a`=0x80000001 regardless of `num_a`.
- Model never asserts done, TIMEOUT=64 → `err`=1 after 64 WAIT cycles, `result` unchanged, `busy`=0.
- Five ops with results 1..5 (HIST_DEPTH=4), then hist rises → `hist_out` reads 5,4,3,2,5. A push coincident with a hist rise → `hist_idx`=0.
- Exec rise during WAIT is ignored. `rst_n` low during WAIT → all outputs return to their reset values asynchronously.
